// File: rtl/iter_div.sv
// rtl/iter_div.sv - multi-cycle unsigned restoring divider, fixed WIDTH-cycle latency (optional ITER_DIV_ZERO_FLAG_EN adds div_zero)
module iter_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
`ifdef ITER_DIV_ZERO_FLAG_EN
   output logic             div_zero,
`endif
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem;     // partial remainder
   logic [WIDTH-1:0] dvd;     // dividend bits still to consume; quotient bits shift in from the right
   logic [WIDTH-1:0] dsr;     // divisor captured at go
`ifdef ITER_DIV_ZERO_FLAG_EN
   logic             dz;      // divisor of the in-flight operation was zero
`endif

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] dvd_nxt;

   // One restoring step: the top bit of the WIDTH+1 bit difference is the borrow.
   // The partial remainder stays below the divisor, so the kept value always fits WIDTH bits;
   // with a zero divisor the remainder only holds a prefix of the dividend, so no borrow appears.
   always_comb begin
      shifted = {rem, dvd[WIDTH-1]};
      diff    = shifted - {1'b0, dsr};
      rem_nxt = shifted[WIDTH-1:0];
      dvd_nxt = {dvd[WIDTH-2:0], 1'b0};
      if (!diff[WIDTH]) begin
         rem_nxt = diff[WIDTH-1:0];
         dvd_nxt = {dvd[WIDTH-2:0], 1'b1};
      end
   end

   // Control FSM with registered busy/done and result registers loaded only on entry to DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         rem       <= '0;
         dvd       <= '0;
         dsr       <= '0;
         quotient  <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef ITER_DIV_ZERO_FLAG_EN
         dz        <= 1'b0;
         div_zero  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (go) begin
                  dvd   <= left;
                  dsr   <= right;
                  rem   <= '0;
                  count <= '0;
                  busy  <= 1'b1;
`ifdef ITER_DIV_ZERO_FLAG_EN
                  dz    <= (right == '0);
`endif
                  state <= BUSY;
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               rem   <= rem_nxt;
               dvd   <= dvd_nxt;
               count <= count + 1'b1;
               if (count == LAST) begin
                  quotient  <= dvd_nxt;
                  remainder <= rem_nxt;
`ifdef ITER_DIV_ZERO_FLAG_EN
                  div_zero  <= dz;
`endif
                  count     <= '0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
